cam_array: RTL and testbench
============================

Name: cam_array

Overview:
- Storage and match side of the CAM. It consumes the read, write and search command set that the CAM decoder issues.
- Holds DEPTH entries of WIDTH bits, each with a valid bit.
- Returns registered read data, and returns search hit/index through a 2-stage compare + priority-encode pipeline.
- Sits directly below the decoder in the CAM datapath.

Parameters:
- WIDTH, 32, entry and search-key width in bits.
- ADDR_WIDTH, 5, index width; DEPTH = 2**ADDR_WIDTH entries (derived localparam, not overridable).

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- read_enable_i  input  1  read request this cycle.
- read_index_i  input  ADDR_WIDTH  entry to read.
- write_enable_i  input  1  write request this cycle.
- write_index_i  input  ADDR_WIDTH  entry to write.
- write_data_i  input  WIDTH  data to write.
- invalidate_enable_i  input  1  clear the valid bit of one entry.
- invalidate_index_i  input  ADDR_WIDTH  entry to invalidate.
- search_enable_i  input  1  search request this cycle.
- search_data_i  input  WIDTH  search key.
- read_valid_o  output  1  1-cycle pulse, read result present.
- read_data_o  output  WIDTH  read data (0 if entry invalid).
- read_entry_valid_o  output  1  valid bit of the entry read.
- search_valid_o  output  1  1-cycle pulse, search result present.
- search_hit_o  output  1  at least one valid entry matched.
- search_index_o  output  ADDR_WIDTH  lowest matching index (0 when no hit).
- search_multi_o  output  1  more than one valid entry matched.
- cmd_conflict_o  output  1  1-cycle pulse, a lower-priority request was dropped.
- valid_count_o  output  ADDR_WIDTH+1  number of valid entries.
- full_o  output  1  valid_count_o == DEPTH.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All valid bits cleared; data storage is not reset.
  - Every output is 0, and both search pipeline stage valids are 0.
  - Reset asserted mid-search discards the in-flight result; no search_valid_o after release.
- Arbitration: one command accepted per cycle, priority read > write > invalidate > search.
  - Every other asserted enable in the same cycle is dropped, not queued.
  - cmd_conflict_o pulses 1 in the next cycle whenever more than one enable was high.
- Read, latency 1:
  - Accepted in cycle N; in N+1, read_valid_o=1 and read_entry_valid_o=valid[idx].
  - read_data_o = mem[idx] if the entry is valid, else 0.
  - read_data_o and read_entry_valid_o hold their last value when read_valid_o=0.
- Write:
  - mem[idx] <= data and valid[idx] <= 1 at the edge ending cycle N.
  - valid_count_o increments only if the entry was previously invalid; overwriting a valid entry leaves the count unchanged.
  - A write when full_o=1 is legal as an overwrite.
- Invalidate:
  - valid[idx] <= 0 at the edge ending cycle N.
  - valid_count_o decrements only if the entry was valid; invalidating an already-invalid entry is a no-op.
- Search, latency 2:
  - Stage 1 (edge ending cycle N) registers match_vec[i] = valid[i] && (mem[i] == key), using array state as of cycle N, which includes all writes and invalidates accepted before N.
  - Stage 2 (edge ending N+1) priority-encodes the lowest set bit and popcount>1.
  - In cycle N+2: search_valid_o=1, search_hit_o = |match_vec, search_index_o = lowest index, search_multi_o as defined.
  - Back-to-back searches every cycle are sustained at full throughput.
  - A write or invalidate accepted in N+1 does not affect the result of a search accepted in N.
  - With no hit: search_hit_o=0, search_index_o=0, search_multi_o=0.
  - Search outputs hold their last value when search_valid_o=0.
- Counter width: valid_count_o never wraps; its range is 0..DEPTH inclusive, hence ADDR_WIDTH+1 bits.
- No X on any output after reset, including reads of never-written entries.

Test Plan:
- Reset, then read index 7 -> next cycle read_valid_o=1, read_entry_valid_o=0, read_data_o=0; valid_count_o=0, full_o=0.
- Write 0xDEADBEEF to idx 3, then read idx 3 -> read_data_o=0xDEADBEEF, read_entry_valid_o=1, latency 1; valid_count_o=1. Rewrite idx 3 -> valid_count_o stays 1.
- Write 0x55 to idx 9 and idx 4, then search 0x55 -> 2 cycles later search_hit_o=1, search_index_o=4, search_multi_o=1. Invalidate idx 4, search again -> index 9, multi 0. Search 0x66 -> hit 0, index 0.
- Same cycle raise read(idx 1), write(idx 2), search -> only the read is accepted; cmd_conflict_o=1 next cycle; entry 2 stays invalid; no search_valid_o.
- Write all 32 entries with the value equal to the index -> valid_count_o=32, full_o=1. Then issue 32 back-to-back searches for keys 0..31 -> 32 consecutive search_valid_o pulses with search_index_o = key.
- Issue a search, assert rst_ni=0 one cycle later -> no search_valid_o after release, all outputs 0, valid_count_o=0.

Source files
------------

// File: rtl/cam_array.sv
// cam_array: CAM storage with registered read, priority-arbitrated commands and
// a 2-stage search pipeline (compare, then priority-encode).
module cam_array #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  read_enable_i,
    input  logic [ADDR_WIDTH-1:0] read_index_i,
    input  logic                  write_enable_i,
    input  logic [ADDR_WIDTH-1:0] write_index_i,
    input  logic [WIDTH-1:0]      write_data_i,
    input  logic                  invalidate_enable_i,
    input  logic [ADDR_WIDTH-1:0] invalidate_index_i,
    input  logic                  search_enable_i,
    input  logic [WIDTH-1:0]      search_data_i,
    output logic                  read_valid_o,
    output logic [WIDTH-1:0]      read_data_o,
    output logic                  read_entry_valid_o,
    output logic                  search_valid_o,
    output logic                  search_hit_o,
    output logic [ADDR_WIDTH-1:0] search_index_o,
    output logic                  search_multi_o,
    output logic                  cmd_conflict_o,
    output logic [ADDR_WIDTH:0]   valid_count_o,
    output logic                  full_o
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid, match_next, match_vec;
    logic rd_go, wr_go, inv_go, srch_go, conflict, s1_valid, multi_hit;
    logic [ADDR_WIDTH-1:0] low_idx;

    assign rd_go   = read_enable_i;
    assign wr_go   = write_enable_i & ~read_enable_i;
    assign inv_go  = invalidate_enable_i & ~read_enable_i & ~write_enable_i;
    assign srch_go = search_enable_i & ~read_enable_i & ~write_enable_i & ~invalidate_enable_i;
    assign conflict = (read_enable_i & (write_enable_i | invalidate_enable_i | search_enable_i))
                    | (write_enable_i & (invalidate_enable_i | search_enable_i))
                    | (invalidate_enable_i & search_enable_i);
    assign full_o = valid_count_o == (ADDR_WIDTH+1)'(DEPTH);

    always_comb begin
        match_next = '0;
        for (int i = 0; i < DEPTH; i++)
            match_next[i] = valid[i] && (mem[i] == search_data_i);
    end

    // Scan downward so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (match_vec[i]) low_idx = ADDR_WIDTH'(i);
    end

    assign multi_hit = |(match_vec & (match_vec - DEPTH'(1)));

    always_ff @(posedge clk_i)
        if (wr_go) mem[write_index_i] <= write_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid              <= '0;
            valid_count_o      <= '0;
            read_valid_o       <= 1'b0;
            read_data_o        <= '0;
            read_entry_valid_o <= 1'b0;
            cmd_conflict_o     <= 1'b0;
            s1_valid           <= 1'b0;
            match_vec          <= '0;
            search_valid_o     <= 1'b0;
            search_hit_o       <= 1'b0;
            search_index_o     <= '0;
            search_multi_o     <= 1'b0;
        end else begin
            cmd_conflict_o <= conflict;
            read_valid_o   <= rd_go;
            if (rd_go) begin
                read_entry_valid_o <= valid[read_index_i];
                read_data_o        <= valid[read_index_i] ? mem[read_index_i] : '0;
            end
            if (wr_go) begin
                valid[write_index_i] <= 1'b1;
                if (!valid[write_index_i]) valid_count_o <= valid_count_o + ONE;
            end else if (inv_go) begin
                valid[invalidate_index_i] <= 1'b0;
                if (valid[invalidate_index_i]) valid_count_o <= valid_count_o - ONE;
            end
            s1_valid <= srch_go;
            if (srch_go) match_vec <= match_next;
            search_valid_o <= s1_valid;
            if (s1_valid) begin
                search_hit_o   <= |match_vec;
                search_index_o <= low_idx;
                search_multi_o <= multi_hit;
            end
        end
    end
endmodule

// File: tb/tb_cam_array.sv
// tb_cam_array: directed plus random stimulus against an array-based reference model.
module tb_cam_array;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        re = 0, we = 0, ie = 0, se = 0;
    logic [4:0]  ri = 0, wi = 0, ii = 0;
    logic [31:0] wd = 0, sd = 0;
    logic        read_valid, read_entry_valid, search_valid, search_hit, search_multi, cmd_conflict, full;
    logic [31:0] read_data;
    logic [4:0]  search_index;
    logic [5:0]  valid_count;

    int checks = 0, fails = 0;
    logic [31:0] mmem [32];
    bit          mvalid [32];
    bit          pend_v, pend_h, pend_m;
    int          pend_i;
    logic [31:0] l_data;
    bit          l_ev, l_hit, l_multi;
    int          l_idx;

    cam_array dut (
        .clk_i(clk), .rst_ni(rst_n),
        .read_enable_i(re), .read_index_i(ri),
        .write_enable_i(we), .write_index_i(wi), .write_data_i(wd),
        .invalidate_enable_i(ie), .invalidate_index_i(ii),
        .search_enable_i(se), .search_data_i(sd),
        .read_valid_o(read_valid), .read_data_o(read_data), .read_entry_valid_o(read_entry_valid),
        .search_valid_o(search_valid), .search_hit_o(search_hit), .search_index_o(search_index),
        .search_multi_o(search_multi), .cmd_conflict_o(cmd_conflict),
        .valid_count_o(valid_count), .full_o(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int vcount();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mvalid[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mvalid[i] = 0;
        pend_v = 0; pend_h = 0; pend_m = 0; pend_i = 0;
        l_data = 0; l_ev = 0; l_hit = 0; l_multi = 0; l_idx = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rv"}, read_valid, 0);
        check({tag, "_rd"}, read_data, 0);
        check({tag, "_rev"}, read_entry_valid, 0);
        check({tag, "_sv"}, search_valid, 0);
        check({tag, "_hit"}, search_hit, 0);
        check({tag, "_idx"}, search_index, 0);
        check({tag, "_multi"}, search_multi, 0);
        check({tag, "_conf"}, cmd_conflict, 0);
        check({tag, "_cnt"}, valid_count, 0);
        check({tag, "_full"}, full, 0);
    endtask

    // One clock: drive, predict from the model, step the edge, update model, compare.
    task automatic cycle(input bit r, input logic [4:0] rix, input bit w, input logic [4:0] wix,
                         input logic [31:0] wdat, input bit inv, input logic [4:0] iix,
                         input bit s, input logic [31:0] key);
        bit conf, nv, nh, nm, erv;
        int ni, cnt, n;
        re = r; ri = rix; we = w; wi = wix; wd = wdat; ie = inv; ii = iix; se = s; sd = key;
        n = int'(r) + int'(w) + int'(inv) + int'(s);
        conf = n > 1;
        erv = r;
        nv = s && !r && !w && !inv;
        cnt = 0; ni = 0;
        for (int i = 31; i >= 0; i--)
            if (mvalid[i] && mmem[i] == key) begin cnt++; ni = i; end
        nh = cnt > 0; nm = cnt > 1;
        if (r) begin
            l_ev = mvalid[rix];
            l_data = mvalid[rix] ? mmem[rix] : 32'h0;
        end
        @(posedge clk); #1;
        if (!r && w) begin mmem[wix] = wdat; mvalid[wix] = 1; end
        else if (!r && !w && inv) mvalid[iix] = 0;
        if (pend_v) begin l_hit = pend_h; l_idx = pend_i; l_multi = pend_m; end
        check("search_valid", search_valid, pend_v);
        pend_v = nv; pend_h = nh; pend_i = ni; pend_m = nm;
        check("read_valid", read_valid, erv);
        check("read_data", read_data, l_data);
        check("read_entry_valid", read_entry_valid, l_ev);
        check("cmd_conflict", cmd_conflict, conf);
        check("search_hit", search_hit, l_hit);
        check("search_index", search_index, l_idx);
        check("search_multi", search_multi, l_multi);
        check("valid_count", valid_count, vcount());
        check("full", full, vcount() == 32);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mmem[i] = 0;
        model_reset();
        #12 rst_n = 1;
        check_zero("reset");
        // Read of a never-written entry
        cycle(1, 7, 0, 0, 0, 0, 0, 0, 0);
        // Write, read back, overwrite
        cycle(0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle(1, 3, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
        // Multi-hit search, invalidate, miss
        cycle(0, 0, 1, 9, 32'h55, 0, 0, 0, 0);
        cycle(0, 0, 1, 4, 32'h55, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        idle(2);
        cycle(0, 0, 0, 0, 0, 1, 4, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        idle(2);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h66);
        idle(2);
        cycle(0, 0, 0, 0, 0, 1, 4, 0, 0);
        // Conflict: read wins, write and search dropped
        cycle(1, 1, 1, 2, 32'h1234, 0, 0, 1, 32'h55);
        idle(2);
        cycle(1, 2, 0, 0, 0, 0, 0, 0, 0);
        // Fill, then back-to-back searches
        for (int i = 0; i < 32; i++) cycle(0, 0, 1, 5'(i), 32'(i), 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'(i));
        idle(2);
        cycle(0, 0, 1, 31, 32'h7, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h7);
        idle(2);
        // Random mix with a small data alphabet so matches and multi-hits occur
        for (int k = 0; k < 1500; k++)
            cycle($urandom_range(0, 5) == 0, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), 32'($urandom_range(0, 7)),
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 1) == 0, 32'($urandom_range(0, 7)));
        idle(2);
        // Reset while a search is in flight
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h3);
        re = 0; we = 0; ie = 0; se = 0;
        #2 rst_n = 0;
        #1 model_reset();
        check_zero("in_reset");
        @(posedge clk); #3 rst_n = 1;
        check_zero("post_reset");
        idle(4);
        cycle(1, 3, 0, 0, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
